ahbl_sram_ctrl: RTL and testbench
=================================

Name: ahbl_sram_ctrl

Overview:
- Parametrised AHB-Lite slave wrapping a single-port, byte-lane-writable synchronous data SRAM.
- Next-generation data memory for the SoC interconnect. Configurable data width, depth and read wait states.
- Adds features the current fixed 32-bit/1K-word zero-wait slave lacks: proper hreadyout stalling, read/write port-collision handling and two-cycle AHB ERROR responses.
- Sits on one slave port of the AHB-Lite interconnect, behind the address decoder.

Parameters:
- DATA_W, 32, bus/memory word width; 32 or 64.
- DEPTH, 1024, number of memory words; power of two, >= 16.
- ADDR_W, 28, width of the slave-local haddr offset.
- WAIT_RD, 0, extra read wait states (0..3) inserted before read data is valid.

Ports:
- clk  input  1  clock.
- rstn  input  1  reset: asynchronous, active-low.
- hsel  input  1  slave select from decoder.
- haddr  input  ADDR_W  slave-local byte address.
- htrans  input  2  transfer type (IDLE/BUSY/NONSEQ/SEQ).
- hwrite  input  1  1 = write.
- hsize  input  3  transfer size (0 = byte, 1 = half, 2 = word, 3 = dword).
- hwdata  input  DATA_W  write data, driven in the data phase.
- hready  input  1  bus-level hready (previous transfer complete).
- hreadyout  output  1  slave ready.
- hresp  output  1  0 = OKAY, 1 = ERROR.
- hrdata  output  DATA_W  read data.

Behaviour:
- Definitions: BL = log2(DATA_W/8); IDX = log2(DEPTH).
  - Word index = haddr[IDX+BL-1:BL].
  - Address phase is accepted when hsel & htrans[1] & hready.
  - IDLE/BUSY or unselected transfers get an OKAY, zero-wait response.
- Legality check at acceptance. The transfer is illegal if any of the following holds; illegal transfers never touch memory:
  - hsize > BL;
  - haddr is not aligned to 2^hsize;
  - haddr[ADDR_W-1:IDX+BL] != 0.
- Byte strobes: 2^hsize contiguous lanes starting at lane haddr[BL-1:0]. Lane k maps to hwdata[8k+7:8k].
- FSM states: IDLE, WR, RD_WAIT, RD, ERR1, ERR2. Transitions out of any state are evaluated on the accepted address phase when hreadyout=1.
  - Legal write -> WR. Data phase with hreadyout=1. The memory write of the strobed lanes happens on the clock edge that ends WR.
  - Legal read -> RD when WAIT_RD=0 and there is no collision; otherwise -> RD_WAIT. The memory read is launched in the address-phase cycle, or in the last RD_WAIT cycle if delayed. hrdata is valid in RD with hreadyout=1.
  - RD_WAIT holds hreadyout=0 and runs a counter loaded with WAIT_RD + collision. It moves to RD when the count reaches 0.
  - Collision: a read address phase accepted while in WR. The write has priority on the single port; the read is issued one cycle later and gets +1 wait state. Read-after-write to the same address therefore returns the new data.
  - Illegal transfer -> ERR1 (hreadyout=0, hresp=1), then ERR2 (hreadyout=1, hresp=1), then IDLE or the next accepted transfer.
  - A read that ends in ERROR drives hrdata = 0.
- hrdata holds its last read value when not in RD; it is never X on the bus.
- Back-to-back transfers: zero bubbles on a write->write stream, or on a read->read stream when WAIT_RD=0.
- Reset values:
  - hreadyout = 1, hresp = 0, hrdata = 0;
  - state = IDLE, wait counter = 0, all registered address-phase fields cleared.
- Reset mid-operation aborts any pending write and any wait or error sequence immediately. Memory contents are not reset; previously written data is retained.
- Unused high lanes: for DATA_W=64, hsize=3 writes all 8 lanes.

Test Plan:
- DATA_W=32, WAIT_RD=0:
  - Write 0xDEADBEEF to 0x000, then read 0x000 back-to-back -> read gets exactly 1 hreadyout=0 cycle (collision), then hrdata=0xDEADBEEF, hresp=0.
  - Word-write 0x11223344 to 0x004, byte-write 0xA5 to 0x007, read 0x004 -> 0xA5223344. Then halfword-write 0xBEEF to 0x004 -> read 0xA522BEEF.
  - Halfword write to 0x001 -> ERR1 (hreadyout=0, hresp=1), then ERR2 (hreadyout=1, hresp=1). A subsequent read of 0x000 still returns 0xDEADBEEF.
  - Read of 0x1000 (word 1024) -> two-cycle ERROR with hrdata=0. A hsize=3 transfer also -> ERROR.
- WAIT_RD=2:
  - 4 consecutive NONSEQ reads -> each shows exactly 2 hreadyout=0 cycles, and data matches prior writes.
  - Assert rstn low during RD_WAIT -> hreadyout=1, hresp=0, hrdata=0 immediately. After release, read of 0x004 returns the value written before reset.
- DATA_W=64, DEPTH=256: dword write 0x0123456789ABCDEF to 0x008 plus a byte write 0xFF to 0x00F -> read returns 0xFF23456789ABCDEF. Address 0x800 -> ERROR.

Source files
------------

// File: rtl/ahbl_sram_ctrl_if.sv
// AHB-Lite slave-port bundle carried between the interconnect and ahbl_sram_ctrl.
interface ahbl_sram_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 28
);
    logic              hsel;
    logic [ADDR_W-1:0] haddr;
    logic [1:0]        htrans;
    logic              hwrite;
    logic [2:0]        hsize;
    logic [DATA_W-1:0] hwdata;
    logic              hready;
    logic              hreadyout;
    logic              hresp;
    logic [DATA_W-1:0] hrdata;

    modport slave (
        input  hsel, haddr, htrans, hwrite, hsize, hwdata, hready,
        output hreadyout, hresp, hrdata
    );

    modport master (
        output hsel, haddr, htrans, hwrite, hsize, hwdata, hready,
        input  hreadyout, hresp, hrdata
    );
endinterface

// File: rtl/ahbl_sram_ctrl.sv
// AHB-Lite slave around a single-port byte-writable SRAM with read wait states,
// write/read port-collision stalling and two-cycle ERROR responses.
module ahbl_sram_ctrl #(
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 1024,
    parameter int ADDR_W  = 28,
    parameter int WAIT_RD = 0
) (
    input  logic            clk,
    input  logic            rstn,
    ahbl_sram_ctrl_if.slave bus
);
    localparam int NB  = DATA_W / 8;
    localparam int BL  = $clog2(NB);
    localparam int IDX = $clog2(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_RD_WAIT,
        S_RD,
        S_ERR1,
        S_ERR2
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [2:0]        r_cnt;
    logic [2:0]        w_cnt_next;
    logic [IDX-1:0]    r_idx;
    logic [NB-1:0]     r_strb;
    logic [DATA_W-1:0] r_hrdata;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_hreadyout;
    logic              w_hresp;
    logic              w_accept;
    logic              w_legal;
    logic              w_rd_en;
    logic              w_wr_en;
    logic              w_clr_rdata;
    logic [IDX-1:0]    w_addr_idx;
    logic [IDX-1:0]    w_rd_idx;
    logic [BL-1:0]     w_off;
    logic [3:0]        w_bytes;
    logic [NB-1:0]     w_strb;
    logic              w_unused;

    assign w_addr_idx = bus.haddr[IDX+BL-1:BL];
    assign w_off      = bus.haddr[BL-1:0];
    assign w_bytes    = 4'd1 << bus.hsize[1:0];
    assign w_legal    = (bus.hsize <= 3'(BL))
                     && ((bus.haddr[2:0] & 3'(w_bytes - 4'd1)) == 3'd0)
                     && (bus.haddr[ADDR_W-1:IDX+BL] == '0);
    // Gating with our own hreadyout keeps a stalled phase from being taken twice.
    assign w_accept   = bus.hsel & bus.htrans[1] & bus.hready & w_hreadyout;
    assign w_unused   = &{1'b0, bus.htrans[0]};

    always_comb begin
        w_strb = '0;
        for (int k = 0; k < NB; k++) begin
            w_strb[k] = (k >= int'(w_off)) && (k < int'(w_off) + int'(w_bytes));
        end
    end

    // NOTE: state and data registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_next      = r_state;
        w_cnt_next  = r_cnt;
        w_rd_en     = 1'b0;
        w_rd_idx    = r_idx;
        w_clr_rdata = 1'b0;
        w_wr_en     = (r_state == S_WR);
        w_hreadyout = !((r_state == S_RD_WAIT) || (r_state == S_ERR1));
        w_hresp     = (r_state == S_ERR1) || (r_state == S_ERR2);
        case (r_state)
            S_RD_WAIT: begin
                w_cnt_next = r_cnt - 3'd1;
                if (r_cnt == 3'd1) begin
                    w_next  = S_RD;
                    w_rd_en = 1'b1;
                end
            end
            S_ERR1: w_next = S_ERR2;
            default: begin
                w_next = S_IDLE;
                if (w_accept) begin
                    if (!w_legal) begin
                        w_next      = S_ERR1;
                        w_clr_rdata = !bus.hwrite;
                    end else if (bus.hwrite) begin
                        w_next = S_WR;
                    end else if ((WAIT_RD == 0) && (r_state != S_WR)) begin
                        w_next   = S_RD;
                        w_rd_en  = 1'b1;
                        w_rd_idx = w_addr_idx;
                    end else begin
                        // The write owns the port this edge, so the read slips one cycle.
                        w_next     = S_RD_WAIT;
                        w_cnt_next = 3'(WAIT_RD) + {2'b00, r_state == S_WR};
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt  <= 3'd0;
            r_idx  <= '0;
            r_strb <= '0;
        end else begin
            r_cnt <= w_cnt_next;
            if (w_accept && w_legal) begin
                r_idx  <= w_addr_idx;
                r_strb <= w_strb;
            end
        end
    end

    // NOTE: the array has no reset so it maps onto an SRAM macro; contents survive rstn.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            for (int k = 0; k < NB; k++) begin
                if (r_strb[k]) r_mem[r_idx][8*k +: 8] <= bus.hwdata[8*k +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)            r_hrdata <= '0;
        else if (w_rd_en)     r_hrdata <= r_mem[w_rd_idx];
        else if (w_clr_rdata) r_hrdata <= '0;
    end

    assign bus.hreadyout = w_hreadyout;
    assign bus.hresp     = w_hresp;
    assign bus.hrdata    = r_hrdata;
endmodule

// File: tb/tb_ahbl_sram_ctrl.sv
// Directed bench: three controller configurations share one AHB-Lite driver,
// which pipelines transfer lists and compares stall, response and data per transfer.
module tb_ahbl_sram_ctrl;
    logic clk;
    logic rstn;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_cmp;
    int unsigned n_bad;

    int          t_sel;
    logic        t_hsel;
    logic [27:0] t_haddr;
    logic [1:0]  t_htrans;
    logic        t_hwrite;
    logic [2:0]  t_hsize;
    logic [63:0] t_hwdata;

    logic        m_rdy;
    logic        m_resp;
    logic [63:0] m_rdata;

    ahbl_sram_ctrl_if #(.DATA_W(32), .ADDR_W(28)) bus0 ();
    ahbl_sram_ctrl_if #(.DATA_W(32), .ADDR_W(28)) bus1 ();
    ahbl_sram_ctrl_if #(.DATA_W(64), .ADDR_W(28)) bus2 ();

    assign bus0.hsel   = t_hsel && (t_sel == 0);
    assign bus0.haddr  = t_haddr;
    assign bus0.htrans = t_htrans;
    assign bus0.hwrite = t_hwrite;
    assign bus0.hsize  = t_hsize;
    assign bus0.hwdata = t_hwdata[31:0];
    assign bus0.hready = bus0.hreadyout;

    assign bus1.hsel   = t_hsel && (t_sel == 1);
    assign bus1.haddr  = t_haddr;
    assign bus1.htrans = t_htrans;
    assign bus1.hwrite = t_hwrite;
    assign bus1.hsize  = t_hsize;
    assign bus1.hwdata = t_hwdata[31:0];
    assign bus1.hready = bus1.hreadyout;

    assign bus2.hsel   = t_hsel && (t_sel == 2);
    assign bus2.haddr  = t_haddr;
    assign bus2.htrans = t_htrans;
    assign bus2.hwrite = t_hwrite;
    assign bus2.hsize  = t_hsize;
    assign bus2.hwdata = t_hwdata;
    assign bus2.hready = bus2.hreadyout;

    ahbl_sram_ctrl #(.DATA_W(32), .DEPTH(1024), .ADDR_W(28), .WAIT_RD(0)) u_dut0 (
        .clk (clk), .rstn(rstn), .bus(bus0.slave));
    ahbl_sram_ctrl #(.DATA_W(32), .DEPTH(1024), .ADDR_W(28), .WAIT_RD(2)) u_dut1 (
        .clk (clk), .rstn(rstn), .bus(bus1.slave));
    ahbl_sram_ctrl #(.DATA_W(64), .DEPTH(256), .ADDR_W(28), .WAIT_RD(0)) u_dut2 (
        .clk (clk), .rstn(rstn), .bus(bus2.slave));

    always_comb begin
        m_rdy   = bus0.hreadyout;
        m_resp  = bus0.hresp;
        m_rdata = {32'h0, bus0.hrdata};
        if (t_sel == 1) begin
            m_rdy   = bus1.hreadyout;
            m_resp  = bus1.hresp;
            m_rdata = {32'h0, bus1.hrdata};
        end else if (t_sel == 2) begin
            m_rdy   = bus2.hreadyout;
            m_resp  = bus2.hresp;
            m_rdata = bus2.hrdata;
        end
    end

    typedef struct {
        bit          wr;
        logic [27:0] addr;
        logic [2:0]  size;
        logic [63:0] wdata;
        int          exp_waits;
        bit          exp_err;
        logic [63:0] exp_rdata;
    } xfer_t;

    xfer_t q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic push(input bit wr, input logic [27:0] addr, input logic [2:0] size,
                        input logic [63:0] wdata, input int waits, input bit err,
                        input logic [63:0] rdata);
        xfer_t x;
        x.wr = wr; x.addr = addr; x.size = size; x.wdata = wdata;
        x.exp_waits = waits; x.exp_err = err; x.exp_rdata = rdata;
        q.push_back(x);
    endtask

    task automatic bus_idle();
        t_hsel = 1'b0; t_htrans = 2'b00; t_hwrite = 1'b0;
        t_haddr = '0; t_hsize = 3'd0; t_hwdata = '0;
    endtask

    // Pipelined master: address of transfer ap overlaps the data phase of transfer dp.
    task automatic run_q(input string name);
        int          n = q.size();
        int          ap = 0;
        int          dp = -1;
        int          guard = 0;
        int          waits [16];
        bit          errs [16];
        logic        resp [16];
        logic [63:0] rd [16];
        logic        rdy;
        for (int i = 0; i < 16; i++) begin
            waits[i] = 0; errs[i] = 1'b0; resp[i] = 1'b0; rd[i] = '0;
        end
        while (dp < n && guard < 100) begin
            guard++;
            if (ap < n) begin
                t_hsel = 1'b1; t_htrans = 2'b10; t_hwrite = q[ap].wr;
                t_haddr = q[ap].addr; t_hsize = q[ap].size;
            end else begin
                t_hsel = 1'b0; t_htrans = 2'b00; t_hwrite = 1'b0;
                t_haddr = '0; t_hsize = 3'd0;
            end
            t_hwdata = '0;
            if (dp >= 0) begin
                if (q[dp].wr) t_hwdata = q[dp].wdata;
            end
            @(negedge clk);
            rdy = m_rdy;
            if (dp >= 0) begin
                if (!rdy) begin
                    waits[dp]++;
                    if (m_resp) errs[dp] = 1'b1;
                end else begin
                    resp[dp] = m_resp;
                    rd[dp]   = m_rdata;
                end
            end
            @(posedge clk);
            #1;
            if (rdy) begin
                dp = ap;
                if (ap < n) ap++;
            end
        end
        bus_idle();
        check({name, " completed"}, 64'(dp), 64'(n));
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s[%0d] waits", name, i), 64'(waits[i]), 64'(q[i].exp_waits));
            check($sformatf("%s[%0d] hresp", name, i), 64'(resp[i]), 64'(q[i].exp_err));
            check($sformatf("%s[%0d] err1", name, i), 64'(errs[i]), 64'(q[i].exp_err));
            if (!q[i].wr) check($sformatf("%s[%0d] hrdata", name, i), rd[i], q[i].exp_rdata);
        end
        q.delete();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;
        t_sel = 0;
        rstn  = 1'b0;
        bus_idle();
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        check("reset hreadyout", 64'(m_rdy), 64'd1);
        check("reset hresp", 64'(m_resp), 64'd0);
        check("reset hrdata", m_rdata, 64'd0);

        // 32-bit, zero wait: write then read back-to-back collides for one stall.
        push(1, 28'h000, 3'd2, 64'hDEADBEEF, 0, 0, 0);
        push(0, 28'h000, 3'd2, 0, 1, 0, 64'hDEADBEEF);
        run_q("raw");

        push(1, 28'h004, 3'd2, 64'h11223344, 0, 0, 0);
        push(1, 28'h007, 3'd0, 64'hA5776655, 0, 0, 0);
        push(0, 28'h004, 3'd2, 0, 1, 0, 64'hA5223344);
        push(1, 28'h004, 3'd1, 64'h9999BEEF, 0, 0, 0);
        push(0, 28'h004, 3'd2, 0, 1, 0, 64'hA522BEEF);
        run_q("lanes");

        push(1, 28'h001, 3'd1, 64'h12345678, 1, 1, 0);
        push(0, 28'h000, 3'd2, 0, 0, 0, 64'hDEADBEEF);
        run_q("misalign");

        push(0, 28'h1000, 3'd2, 0, 1, 1, 64'h0);
        push(0, 28'h004, 3'd2, 0, 0, 0, 64'hA522BEEF);
        push(0, 28'h000, 3'd3, 0, 1, 1, 64'h0);
        run_q("range");

        push(0, 28'h000, 3'd2, 0, 0, 0, 64'hDEADBEEF);
        push(0, 28'h004, 3'd2, 0, 0, 0, 64'hA522BEEF);
        run_q("rd_stream");
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("hrdata hold", m_rdata, 64'hA522BEEF);

        // 32-bit, two read wait states.
        t_sel = 1;
        push(1, 28'h000, 3'd2, 64'h01010101, 0, 0, 0);
        push(1, 28'h004, 3'd2, 64'h02020202, 0, 0, 0);
        push(1, 28'h008, 3'd2, 64'h03030303, 0, 0, 0);
        push(1, 28'h00C, 3'd2, 64'h04040404, 0, 0, 0);
        run_q("w2_fill");
        push(0, 28'h000, 3'd2, 0, 2, 0, 64'h01010101);
        push(0, 28'h004, 3'd2, 0, 2, 0, 64'h02020202);
        push(0, 28'h008, 3'd2, 0, 2, 0, 64'h03030303);
        push(0, 28'h00C, 3'd2, 0, 2, 0, 64'h04040404);
        run_q("w2_reads");

        @(negedge clk);
        t_hsel = 1'b1; t_htrans = 2'b10; t_hwrite = 1'b0; t_haddr = 28'h004; t_hsize = 3'd2;
        @(posedge clk);
        #1 bus_idle();
        check("pre-reset stall", 64'(m_rdy), 64'd0);
        rstn = 1'b0;
        #1;
        check("mid-reset hreadyout", 64'(m_rdy), 64'd1);
        check("mid-reset hresp", 64'(m_resp), 64'd0);
        check("mid-reset hrdata", m_rdata, 64'd0);
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        push(0, 28'h004, 3'd2, 0, 2, 0, 64'h02020202);
        run_q("w2_retain");

        // 64-bit, 256 words.
        t_sel = 2;
        push(1, 28'h008, 3'd3, 64'h0123456789ABCDEF, 0, 0, 0);
        push(1, 28'h00F, 3'd0, 64'hFF11223344556677, 0, 0, 0);
        push(0, 28'h008, 3'd3, 0, 1, 0, 64'hFF23456789ABCDEF);
        push(0, 28'h800, 3'd3, 0, 1, 1, 64'h0);
        run_q("d64");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
